watch_ctrl: RTL

WATCH_CTRL -- requirements
Module: watch_ctrl

---
 rtl/watch_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/watch_ctrl.sv
// 24-hour BCD watch: RUN counts minutes from a prescaled clock,
// SET_HR / SET_MIN adjust the time from a debounced increment button.
module watch_ctrl #(
    parameter int unsigned TICKS_PER_MIN = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] Hour1,
    output logic [3:0] Hour2,
    output logic [3:0] Min1,
    output logic [3:0] Min2,
    output logic [1:0] set_mode,
    output logic       chime
);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_SET_HR  = 2'b01,
        S_SET_MIN = 2'b10
    } state_e;

    localparam logic [15:0] PRE_MAX = 16'(TICKS_PER_MIN - 1);

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic        mode_prev_q, inc_prev_q;
    logic [3:0]  h1_q, h1_d;
    logic [3:0]  h2_q, h2_d;
    logic [3:0]  m1_q, m1_d;
    logic [3:0]  m2_q, m2_d;
    logic        chime_q, chime_d;

    logic mode_rise;
    logic inc_rise;
    logic run_tick;
    logic hr_inc;
    logic min_inc;
    logic min_wrap;
    logic min_adv;
    logic hr_adv;

    assign mode_rise = mode_btn & ~mode_prev_q;
    assign inc_rise  = inc_btn & ~inc_prev_q;

    assign run_tick = (state_q == S_RUN) && (presc_q == PRE_MAX);
    // A mode edge in the same cycle swallows the increment.
    assign hr_inc   = (state_q == S_SET_HR) && inc_rise && !mode_rise;
    assign min_inc  = (state_q == S_SET_MIN) && inc_rise && !mode_rise;

    assign min_wrap = (m1_q >= 4'd5) && (m2_q >= 4'd9);
    assign min_adv  = run_tick || min_inc;
    assign hr_adv   = (run_tick && min_wrap) || hr_inc;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:     if (mode_rise) state_d = S_SET_HR;
            S_SET_HR:  if (mode_rise) state_d = S_SET_MIN;
            S_SET_MIN: if (mode_rise) state_d = S_RUN;
            default:   state_d = S_RUN;
        endcase
    end

    always_comb begin
        presc_d = '0;
        if (state_q == S_RUN && !mode_rise && !run_tick) begin
            presc_d = presc_q + 16'd1;
        end
    end

    always_comb begin
        m1_d = m1_q;
        m2_d = m2_q;
        if (min_adv) begin
            if (m2_q >= 4'd9) begin
                m2_d = 4'd0;
                m1_d = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
            end else begin
                m2_d = m2_q + 4'd1;
            end
        end
    end

    // Comparisons use >= so a corrupted digit falls back into range.
    always_comb begin
        h1_d = h1_q;
        h2_d = h2_q;
        if (hr_adv) begin
            if ((h1_q >= 4'd2 && h2_q >= 4'd3) || h1_q > 4'd2) begin
                h1_d = 4'd0;
                h2_d = 4'd0;
            end else if (h2_q >= 4'd9) begin
                h1_d = h1_q + 4'd1;
                h2_d = 4'd0;
            end else begin
                h2_d = h2_q + 4'd1;
            end
        end
    end

    assign chime_d = run_tick && min_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            presc_q     <= '0;
            mode_prev_q <= mode_btn;
            inc_prev_q  <= inc_btn;
            h1_q        <= 4'd0;
            h2_q        <= 4'd0;
            m1_q        <= 4'd0;
            m2_q        <= 4'd0;
            chime_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            mode_prev_q <= mode_btn;
            inc_prev_q  <= inc_btn;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            m1_q        <= m1_d;
            m2_q        <= m2_d;
            chime_q     <= chime_d;
        end
    end

    assign Hour1    = h1_q;
    assign Hour2    = h2_q;
    assign Min1     = m1_q;
    assign Min2     = m2_q;
    assign set_mode = state_q;
    assign chime    = chime_q;

endmodule
